// File: rtl/bpu_pkg.sv
// Shared branch-type codes, 2-bit counter constants and counter helper
// for the multi-lane branch prediction unit.
package bpu_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_CALL = 2'b10,
      BR_RET  = 2'b11
   } br_type_e;

   localparam logic [1:0] CNT_INIT  = 2'b01;
   localparam logic [1:0] CNT_TAKEN = 2'b10;
   localparam logic [1:0] CNT_MAX   = 2'b11;
   localparam logic [1:0] CNT_MIN   = 2'b00;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'b01;
      else       return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'b01;
   endfunction

   // A BTB entry pairs a partial tag and a word-aligned target with the
   // branch type. The tag and target widths follow the top-level address
   // and tag parameters, so the concrete entry type is declared by the
   // BTB owner from these field widths.
   function automatic int btb_entry_bits(input int tag_w, input int addr_w);
      return tag_w + (addr_w - 2) + 2;
   endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack. A push writes at ptr+1 and advances,
// a pop only moves the pointer back, and a recovery rewrites the pointer
// (optionally with one entry) from an execute-side snapshot.
module bpu_ras #(
   parameter int ADDR_WIDTH = 32,
   parameter int RAS_DEPTH  = 3
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] push_data,
   input  logic                  recover,
   input  logic [RAS_DEPTH-1:0]  rec_ptr,
   input  logic                  rec_write,
   input  logic [ADDR_WIDTH-1:0] rec_data,
   output logic [ADDR_WIDTH-1:0] top,
   output logic [RAS_DEPTH-1:0]  ptr
);

   localparam int RAS_N = 1 << RAS_DEPTH;

   logic [ADDR_WIDTH-1:0] mem [RAS_N];
   logic [RAS_DEPTH-1:0]  ptr_inc;

   assign ptr_inc = ptr + RAS_DEPTH'(1);
   assign top     = mem[ptr];

   // Stack storage and pointer; recovery outranks the speculative push/pop.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr <= '0;
         for (int i = 0; i < RAS_N; i++) mem[i] <= '0;
      end else if (recover) begin
         ptr <= rec_ptr;
         if (rec_write) mem[rec_ptr] <= rec_data;
      end else if (push) begin
         ptr          <= ptr_inc;
         mem[ptr_inc] <= push_data;
      end else if (pop) begin
         ptr <= ptr - RAS_DEPTH'(1);
      end
   end

endmodule

// File: rtl/bpu_multi_lane.sv
// N-lane branch prediction unit: tagged BTB, gshare PHT with a speculative
// global history, and a return address stack. Lookup is combinational in
// the fetch cycle; execute trains the tables and repairs speculative state.
module bpu_multi_lane
   import bpu_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int BTB_DEPTH   = 6,
   parameter int TAG_WIDTH   = 12,
   parameter int GHR_WIDTH   = 8,
   parameter int RAS_DEPTH   = 3,
   localparam int LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   ifVld,
   input  logic [ADDR_WIDTH-1:0]  ifPC,
   output logic [ADDR_WIDTH-1:0]  pdPC,
   output logic                   pdBranch,
   output logic [LANE_W-1:0]      pdLane,
   output logic [FETCH_WIDTH-1:0] pdKnown,
   output logic [GHR_WIDTH-1:0]   pdGhr,
   output logic [RAS_DEPTH-1:0]   pdRasPtr,
   input  logic                   exVld,
   input  logic [ADDR_WIDTH-1:0]  exPC,
   input  logic [ADDR_WIDTH-1:0]  exPCTar,
   input  logic [1:0]             exType,
   input  logic                   exBranch,
   input  logic                   exWrong,
   input  logic [GHR_WIDTH-1:0]   exGhr,
   input  logic [RAS_DEPTH-1:0]   exRasPtr
);

   localparam int BTB_N = 1 << BTB_DEPTH;
   localparam int PHT_N = 1 << GHR_WIDTH;
   localparam int TGT_W = ADDR_WIDTH - 2;

   typedef struct packed {
      logic [TAG_WIDTH-1:0] tag;
      logic [TGT_W-1:0]     target;
      br_type_e             typ;
   } btb_entry_t;

   logic [BTB_N-1:0]      btb_vld;
   btb_entry_t            btb_mem [BTB_N];
   logic [1:0]            pht [PHT_N];
   logic [GHR_WIDTH-1:0]  ghr;
   logic [ADDR_WIDTH-1:0] ras_top;
   logic [RAS_DEPTH-1:0]  ras_ptr;

   logic [ADDR_WIDTH-1:0]  lane_pc  [FETCH_WIDTH];
   btb_entry_t             lane_ent [FETCH_WIDTH];
   logic [1:0]             lane_cnt [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0] lane_hit;
   logic [FETCH_WIDTH-1:0] lane_taken;

   logic                  win_found;
   logic [LANE_W-1:0]     win_lane;
   btb_entry_t            win_ent;
   logic [ADDR_WIDTH-1:0] win_pc;
   logic                  cond_seen;

   br_type_e              ex_type;
   logic                  ex_rec;
   logic [BTB_DEPTH-1:0]  ex_btb_idx;
   logic [GHR_WIDTH-1:0]  ex_pht_idx;
   logic                  btb_we;
   logic [RAS_DEPTH-1:0]  rec_ptr;
   logic                  ras_push;
   logic                  ras_pop;
   logic                  unused_tar_lsb;

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
      assign lane_pc[g]    = ifPC + ADDR_WIDTH'(4 * g);
      assign lane_ent[g]   = btb_mem[lane_pc[g][BTB_DEPTH+1:2]];
      assign lane_cnt[g]   = pht[lane_pc[g][GHR_WIDTH+1:2] ^ ghr];
      assign lane_hit[g]   = btb_vld[lane_pc[g][BTB_DEPTH+1:2]]
                          && (lane_ent[g].tag == lane_pc[g][BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2]);
      assign lane_taken[g] = lane_hit[g]
                          && ((lane_ent[g].typ == BR_COND) ? (lane_cnt[g] >= CNT_TAKEN)
                                                           : (lane_ent[g].typ != BR_NONE));
   end

   // Lowest taken lane wins; also note any hit conditional up to the winner.
   always_comb begin
      win_found = 1'b0;
      win_lane  = '0;
      win_ent   = '0;
      win_pc    = ifPC;
      cond_seen = 1'b0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (!win_found) begin
            if (lane_hit[i] && lane_ent[i].typ == BR_COND) cond_seen = 1'b1;
            if (lane_taken[i]) begin
               win_found = 1'b1;
               win_lane  = LANE_W'(i);
               win_ent   = lane_ent[i];
               win_pc    = lane_pc[i];
            end
         end
      end
   end

   // Next fetch PC: RAS top for a return with a non-zero top, else BTB target or fall-through.
   always_comb begin
      pdPC = ifPC + ADDR_WIDTH'(4 * FETCH_WIDTH);
      if (win_found) begin
         if (win_ent.typ == BR_RET && ras_top != '0) pdPC = ras_top;
         else                                        pdPC = {win_ent.target, 2'b00};
      end
   end

   assign pdBranch = win_found;
   assign pdLane   = win_lane;
   assign pdKnown  = lane_hit;
   assign pdGhr    = ghr;
   assign pdRasPtr = ras_ptr;

   assign ex_type        = br_type_e'(exType);
   assign ex_rec         = exVld && exWrong;
   assign ex_btb_idx     = exPC[BTB_DEPTH+1:2];
   assign ex_pht_idx     = exPC[GHR_WIDTH+1:2] ^ exGhr;
   assign btb_we         = exVld && (ex_type != BR_NONE) && (exBranch || ex_type != BR_COND);
   assign unused_tar_lsb = ^exPCTar[1:0];

   // Global history: recovery restores from the snapshot, otherwise speculative shift.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ghr <= '0;
      end else if (ex_rec) begin
         ghr <= (ex_type == BR_COND) ? {exGhr[GHR_WIDTH-2:0], exBranch} : exGhr;
      end else if (ifVld) begin
         if (win_found && win_ent.typ == BR_COND) ghr <= {ghr[GHR_WIDTH-2:0], 1'b1};
         else if (cond_seen)                       ghr <= {ghr[GHR_WIDTH-2:0], 1'b0};
      end
   end

   // Pattern history counters trained by resolved conditionals.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= CNT_INIT;
      end else if (exVld && ex_type == BR_COND) begin
         pht[ex_pht_idx] <= cnt_next(pht[ex_pht_idx], exBranch);
      end
   end

   // BTB valid bits live in flops so reset clears the whole table at once.
   always_ff @(posedge clk) begin
      if (!rstn)       btb_vld <= '0;
      else if (btb_we) btb_vld[ex_btb_idx] <= 1'b1;
   end

   // BTB payload; contents are don't-care while the valid bit is clear.
   always_ff @(posedge clk) begin
      if (rstn && btb_we) begin
         btb_mem[ex_btb_idx] <= '{tag:    exPC[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2],
                                  target: exPCTar[ADDR_WIDTH-1:2],
                                  typ:    ex_type};
      end
   end

   always_comb begin
      rec_ptr = exRasPtr;
      if (ex_type == BR_CALL)     rec_ptr = exRasPtr + RAS_DEPTH'(1);
      else if (ex_type == BR_RET) rec_ptr = exRasPtr - RAS_DEPTH'(1);
   end

   assign ras_push = ifVld && !ex_rec && win_found && (win_ent.typ == BR_CALL);
   assign ras_pop  = ifVld && !ex_rec && win_found && (win_ent.typ == BR_RET);

   bpu_ras #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAS_DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rstn      (rstn),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (win_pc + ADDR_WIDTH'(4)),
      .recover   (ex_rec),
      .rec_ptr   (rec_ptr),
      .rec_write (ex_type == BR_CALL),
      .rec_data  (exPC + ADDR_WIDTH'(4)),
      .top       (ras_top),
      .ptr       (ras_ptr)
   );

endmodule

// File: tb/tb_bpu_multi_lane.sv
// Directed bench for bpu_multi_lane with default parameters (2 lanes,
// 64-entry BTB, 8-bit history, 8-entry RAS).
module tb_bpu_multi_lane;

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_COND = 2'b01;
   localparam logic [1:0] T_CALL = 2'b10;
   localparam logic [1:0] T_RET  = 2'b11;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_vld;
   logic [31:0] if_pc;
   logic [31:0] pd_pc;
   logic        pd_branch;
   logic [0:0]  pd_lane;
   logic [1:0]  pd_known;
   logic [7:0]  pd_ghr;
   logic [2:0]  pd_ras_ptr;
   logic        ex_vld;
   logic [31:0] ex_pc;
   logic [31:0] ex_pc_tar;
   logic [1:0]  ex_type;
   logic        ex_branch;
   logic        ex_wrong;
   logic [7:0]  ex_ghr;
   logic [2:0]  ex_ras_ptr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bpu_multi_lane dut (
      .clk      (clk),
      .rstn     (rstn),
      .ifVld    (if_vld),
      .ifPC     (if_pc),
      .pdPC     (pd_pc),
      .pdBranch (pd_branch),
      .pdLane   (pd_lane),
      .pdKnown  (pd_known),
      .pdGhr    (pd_ghr),
      .pdRasPtr (pd_ras_ptr),
      .exVld    (ex_vld),
      .exPC     (ex_pc),
      .exPCTar  (ex_pc_tar),
      .exType   (ex_type),
      .exBranch (ex_branch),
      .exWrong  (ex_wrong),
      .exGhr    (ex_ghr),
      .exRasPtr (ex_ras_ptr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_go(input logic [31:0] pc, input logic [31:0] tar, input logic [1:0] typ,
                        input logic br, input logic wrong, input logic [7:0] g, input logic [2:0] rp);
      ex_vld     = 1'b1;
      ex_pc      = pc;
      ex_pc_tar  = tar;
      ex_type    = typ;
      ex_branch  = br;
      ex_wrong   = wrong;
      ex_ghr     = g;
      ex_ras_ptr = rp;
      tick();
      ex_vld   = 1'b0;
      ex_wrong = 1'b0;
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tar, input logic [1:0] typ,
                        input logic br, input logic [7:0] g);
      ex_go(pc, tar, typ, br, 1'b0, g, 3'd0);
   endtask

   task automatic fetch(input logic [31:0] pc);
      if_pc  = pc;
      if_vld = 1'b1;
      tick();
      if_vld = 1'b0;
   endtask

   task automatic peek(input logic [31:0] pc);
      if_pc = pc;
      #1;
   endtask

   initial begin
      rstn = 1'b0; if_vld = 1'b0; if_pc = 32'h1000;
      ex_vld = 1'b0; ex_pc = '0; ex_pc_tar = '0; ex_type = T_NONE;
      ex_branch = 1'b0; ex_wrong = 1'b0; ex_ghr = '0; ex_ras_ptr = '0;
      tick(); tick();
      rstn = 1'b1;

      // reset state
      peek(32'h1000);
      check("rst_branch", pd_branch,  0);
      check("rst_pc",     pd_pc,      32'h1008);
      check("rst_known",  pd_known,   0);
      check("rst_lane",   pd_lane,    0);
      check("rst_ghr",    pd_ghr,     0);
      check("rst_rasptr", pd_ras_ptr, 0);

      // conditional at 0x1004, lane 1
      for (int k = 0; k < 4; k++) train(32'h1004, 32'h2000, T_COND, 1'b1, 8'h00);
      peek(32'h1000);
      check("cond_branch", pd_branch, 1);
      check("cond_lane",   pd_lane,   1);
      check("cond_pc",     pd_pc,     32'h2000);
      check("cond_known",  pd_known,  2'b10);
      fetch(32'h1000);
      check("ghr_shift1", pd_ghr, 8'h01);
      // history changed: index 1^1=0 hits an untrained counter
      peek(32'h1000);
      check("ghr_alias_branch", pd_branch, 0);
      check("ghr_alias_pc",     pd_pc,     32'h1008);
      check("ghr_alias_known",  pd_known,  2'b10);
      fetch(32'h1000);
      check("ghr_shift0", pd_ghr, 8'h02);
      ex_go(32'h0, 32'h0, T_NONE, 1'b0, 1'b1, 8'h00, 3'd0);
      check("ghr_restore", pd_ghr, 8'h00);

      // lane priority
      train(32'h1000, 32'h3000, T_COND, 1'b1, 8'h00);
      train(32'h1000, 32'h3000, T_COND, 1'b1, 8'h00);
      peek(32'h1000);
      check("prio_lane",  pd_lane,  0);
      check("prio_pc",    pd_pc,    32'h3000);
      check("prio_known", pd_known, 2'b11);

      // call then return
      train(32'h1000, 32'h5000, T_CALL, 1'b1, 8'h00);
      peek(32'h1000);
      check("call_pc", pd_pc, 32'h5000);
      fetch(32'h1000);
      check("call_ptr", pd_ras_ptr, 1);
      check("call_ghr", pd_ghr,     0);
      train(32'h3000, 32'h7000, T_RET, 1'b1, 8'h00);
      peek(32'h3000);
      check("ret_pc",    pd_pc,    32'h1004);
      check("ret_known", pd_known, 2'b01);
      fetch(32'h3000);
      check("ret_ptr", pd_ras_ptr, 0);
      peek(32'h3000);
      check("ret_top0_pc", pd_pc, 32'h7000);

      // nine calls wrap an 8-entry stack
      for (int k = 0; k < 9; k++) train(32'h1000 + 32'(8 * k), 32'h5000, T_CALL, 1'b1, 8'h00);
      for (int k = 0; k < 9; k++) fetch(32'h1000 + 32'(8 * k));
      check("wrap_ptr", pd_ras_ptr, 1);
      train(32'h3000, 32'h7000, T_RET, 1'b1, 8'h00);
      peek(32'h3000);
      check("wrap_top", pd_pc, 32'h1044);
      fetch(32'h3000);
      peek(32'h3000);
      check("wrap_next", pd_pc, 32'h103C);

      // mispredict overrides a same-cycle fetch of a call
      if_pc  = 32'h1008;
      if_vld = 1'b1;
      ex_go(32'h1100, 32'h0, T_COND, 1'b0, 1'b1, 8'hA5, 3'd3);
      if_vld = 1'b0;
      check("mp_ghr", pd_ghr,     8'h4A);
      check("mp_ptr", pd_ras_ptr, 3);
      ex_go(32'h20E0, 32'h2400, T_CALL, 1'b1, 1'b1, 8'h0F, 3'd5);
      check("mp_call_ghr", pd_ghr,     8'h0F);
      check("mp_call_ptr", pd_ras_ptr, 6);
      peek(32'h3000);
      check("mp_call_top", pd_pc, 32'h20E4);
      ex_go(32'h20F0, 32'h2200, T_RET, 1'b1, 1'b1, 8'h33, 3'd2);
      check("mp_ret_ghr", pd_ghr,     8'h33);
      check("mp_ret_ptr", pd_ras_ptr, 1);
      ex_go(32'h0, 32'h0, T_NONE, 1'b0, 1'b1, 8'h00, 3'd0);

      // saturation: 5 taken then 1 not-taken keeps predicting taken
      for (int k = 0; k < 5; k++) train(32'h1A34, 32'h4440, T_COND, 1'b1, 8'h00);
      train(32'h1A34, 32'h4440, T_COND, 1'b0, 8'h00);
      peek(32'h1A30);
      check("sat_branch", pd_branch, 1);
      check("sat_lane",   pd_lane,   1);
      check("sat_pc",     pd_pc,     32'h4440);

      // fall-through wraps at the top of the address space
      peek(32'hFFFF_FFFC);
      check("wrap_addr_pc", pd_pc, 32'h0000_0004);

      // reset mid-stream beats fetch and training in the same cycle
      fetch(32'h1A30);
      check("pre_rst_ghr", pd_ghr, 8'h01);
      if_pc = 32'h1A30; if_vld = 1'b1; rstn = 1'b0;
      train(32'h1A30, 32'h9000, T_CALL, 1'b1, 8'h00);
      rstn = 1'b1; if_vld = 1'b0;
      peek(32'h1A30);
      check("mid_rst_known",  pd_known,   0);
      check("mid_rst_branch", pd_branch,  0);
      check("mid_rst_pc",     pd_pc,      32'h1A38);
      check("mid_rst_ghr",    pd_ghr,     0);
      check("mid_rst_ptr",    pd_ras_ptr, 0);
      // counters back at weakly-not-taken: one taken update flips the prediction
      train(32'h1A34, 32'h4440, T_COND, 1'b1, 8'h00);
      peek(32'h1A30);
      check("post_rst_branch", pd_branch, 1);
      check("post_rst_pc",     pd_pc,     32'h4440);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
